// File: rtl/mmcam_match_store.sv
// Multi-entry matching store: pairs L/R operand tokens by key and emits fired packets.
// Optional duplicate-token detection is compiled in with `define MMCAM_DUP_DETECT_EN.
module mmcam_match_store #(
  parameter int DEPTH  = 8,
  parameter int KEY_W  = 18,
  parameter int DATA_W = 16
) (
  input  logic                       CP,
  input  logic                       MR,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [KEY_W-1:0]           IN_KEY,
  input  logic                       IN_LR,
  input  logic [DATA_W-1:0]          IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [KEY_W-1:0]           OUT_KEY,
  output logic [DATA_W-1:0]          OUT_DATA_L,
  output logic [DATA_W-1:0]          OUT_DATA_R,
  output logic [$clog2(DEPTH+1)-1:0] OCCUPANCY,
  output logic                       FULL,
  output logic                       DUP_ERR
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  lr;
  logic [KEY_W-1:0]  key [DEPTH];
  logic [DATA_W-1:0] dat [DEPTH];
  logic [OW-1:0]     occ;

  logic              hit;
  logic              dup;
  logic [IW-1:0]     hit_idx;
  logic [IW-1:0]     free_idx;
  logic              slot_free;
  logic              accept;
  logic              fire;
  logic              store;
  logic [DATA_W-1:0] hit_data;

  // Associative search; descending scan so the lowest index wins
  always_comb begin
    hit      = 1'b0;
    dup      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (vld[i] && key[i] == IN_KEY && lr[i] != IN_LR) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
`ifdef MMCAM_DUP_DETECT_EN
      if (vld[i] && key[i] == IN_KEY && lr[i] == IN_LR)
        dup = 1'b1;
`endif
      if (!vld[i])
        free_idx = IW'(i);
    end
    if (hit)
      dup = 1'b0;
  end

  assign FULL      = (occ == OW'(DEPTH));
  assign slot_free = !OUT_VALID || OUT_READY;
  assign IN_READY  = slot_free && (hit || dup || !FULL);
  assign accept    = IN_VALID && IN_READY;
  assign fire      = accept && hit;
  assign store     = accept && !hit && !dup;
  assign hit_data  = dat[hit_idx];
  assign OCCUPANCY = occ;

  // Entry payload storage; contents are only meaningful while vld is set
  always_ff @(posedge CP) begin
    if (!MR && store) begin
      key[free_idx] <= IN_KEY;
      lr[free_idx]  <= IN_LR;
      dat[free_idx] <= IN_DATA;
    end
  end

  // Valid bits, occupancy and the registered output packet
  always_ff @(posedge CP) begin
    if (MR) begin
      vld        <= '0;
      occ        <= '0;
      OUT_VALID  <= 1'b0;
      OUT_KEY    <= '0;
      OUT_DATA_L <= '0;
      OUT_DATA_R <= '0;
    end else if (fire) begin
      vld[hit_idx] <= 1'b0;
      occ          <= occ - OW'(1);
      OUT_VALID    <= 1'b1;
      OUT_KEY      <= IN_KEY;
      if (IN_LR) begin
        OUT_DATA_L <= hit_data;
        OUT_DATA_R <= IN_DATA;
      end else begin
        OUT_DATA_L <= IN_DATA;
        OUT_DATA_R <= hit_data;
      end
    end else begin
      if (OUT_READY)
        OUT_VALID <= 1'b0;
      if (store) begin
        vld[free_idx] <= 1'b1;
        occ           <= occ + OW'(1);
      end
    end
  end

`ifdef MMCAM_DUP_DETECT_EN
  // One-cycle pulse after a duplicate token is accepted and dropped
  always_ff @(posedge CP) begin
    if (MR)
      DUP_ERR <= 1'b0;
    else
      DUP_ERR <= accept && dup;
  end
`else
  assign DUP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mmcam_match_store.sv
// Self-checking bench for mmcam_match_store (DEPTH=8, KEY_W=18, DATA_W=16).
// Expected fired packets are queued at stimulus time and popped when the DUT fires.
module tb_mmcam_match_store;

  logic        CP = 1'b0;
  logic        MR = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [17:0] IN_KEY = '0;
  logic        IN_LR = 1'b0;
  logic [15:0] IN_DATA = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [17:0] OUT_KEY;
  logic [15:0] OUT_DATA_L;
  logic [15:0] OUT_DATA_R;
  logic [3:0]  OCCUPANCY;
  logic        FULL;
  logic        DUP_ERR;

  typedef struct packed {
    logic [17:0] k;
    logic [15:0] l;
    logic [15:0] r;
  } pkt_t;

  pkt_t q[$];
  pkt_t e;
  int   vectors = 0;
  int   miscompares = 0;
  bit   acc;

  mmcam_match_store #(.DEPTH(8), .KEY_W(18), .DATA_W(16)) dut (
    .CP(CP), .MR(MR),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_KEY(IN_KEY), .IN_LR(IN_LR), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_KEY(OUT_KEY), .OUT_DATA_L(OUT_DATA_L), .OUT_DATA_R(OUT_DATA_R),
    .OCCUPANCY(OCCUPANCY), .FULL(FULL), .DUP_ERR(DUP_ERR)
  );

  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    @(negedge CP);
  endtask

  task automatic put(input logic [17:0] k, input logic s,
                     input logic [15:0] d, output bit a);
    IN_VALID = 1'b1;
    IN_KEY   = k;
    IN_LR    = s;
    IN_DATA  = d;
    #1 a = IN_READY;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic do_reset();
    MR = 1'b1;
    tick();
    MR = 1'b0;
    OUT_READY = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    MR = 1'b1;
    tick();
    tick();
    MR = 1'b0;
    vectors++;
    if (OCCUPANCY !== 4'd0 || FULL !== 1'b0 || OUT_VALID !== 1'b0 ||
        DUP_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state occ=%0d full=%b ov=%b dup=%b need 0/0/0/0",
               OCCUPANCY, FULL, OUT_VALID, DUP_ERR);
    end
    vectors++;
    if (OUT_KEY !== 18'd0 || OUT_DATA_L !== 16'd0 || OUT_DATA_R !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_out key=%h l=%h r=%h need 0", OUT_KEY, OUT_DATA_L, OUT_DATA_R);
    end
    #1;
    vectors++;
    if (IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%b need 1", IN_READY);
    end
  endtask

  task automatic test_basic_pair();
    put(18'h00123, 1'b0, 16'h1111, acc);
    vectors++;
    if (acc !== 1'b1 || OCCUPANCY !== 4'd1 || OUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_store acc=%b occ=%0d ov=%b need 1/1/0", acc, OCCUPANCY, OUT_VALID);
    end
    tick();
    tick();
    q.push_back('{k: 18'h00123, l: 16'h1111, r: 16'h2222});
    put(18'h00123, 1'b1, 16'h2222, acc);
    e = q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || OUT_KEY !== e.k || OUT_DATA_L !== e.l ||
        OUT_DATA_R !== e.r || OCCUPANCY !== 4'd0) begin
      miscompares++;
      $display("FAIL basic_fire ov=%b key=%h l=%h r=%h occ=%0d need 1/%h/%h/%h/0",
               OUT_VALID, OUT_KEY, OUT_DATA_L, OUT_DATA_R, OCCUPANCY, e.k, e.l, e.r);
    end
    tick();
    vectors++;
    if (OUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain ov=%b need 0", OUT_VALID);
    end
  endtask

  task automatic test_reverse();
    put(18'd5, 1'b1, 16'hAAAA, acc);
    q.push_back('{k: 18'd5, l: 16'hBBBB, r: 16'hAAAA});
    put(18'd5, 1'b0, 16'hBBBB, acc);
    e = q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || OUT_KEY !== e.k || OUT_DATA_L !== e.l ||
        OUT_DATA_R !== e.r) begin
      miscompares++;
      $display("FAIL reverse ov=%b key=%h l=%h r=%h need 1/%h/%h/%h",
               OUT_VALID, OUT_KEY, OUT_DATA_L, OUT_DATA_R, e.k, e.l, e.r);
    end
    tick();
  endtask

  task automatic test_partial_key();
    put(18'h00001, 1'b0, 16'h0001, acc);
    put(18'h20001, 1'b1, 16'h0002, acc);
    vectors++;
    if (OUT_VALID !== 1'b0 || OCCUPANCY !== 4'd2) begin
      miscompares++;
      $display("FAIL partial_key ov=%b occ=%0d need 0/2", OUT_VALID, OCCUPANCY);
    end
    do_reset();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++)
      put(18'(i), 1'b0, 16'(16'h0100 + i), acc);
    vectors++;
    if (FULL !== 1'b1 || OCCUPANCY !== 4'd8) begin
      miscompares++;
      $display("FAIL full_set full=%b occ=%0d need 1/8", FULL, OCCUPANCY);
    end
    IN_VALID = 1'b1;
    IN_KEY   = 18'd9;
    IN_LR    = 1'b1;
    IN_DATA  = 16'h9999;
    #1;
    vectors++;
    if (IN_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL full_stall ready=%b need 0", IN_READY);
    end
    tick();
    IN_VALID = 1'b0;
    vectors++;
    if (OCCUPANCY !== 4'd8 || OUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL full_nochange occ=%0d ov=%b need 8/0", OCCUPANCY, OUT_VALID);
    end
    q.push_back('{k: 18'd3, l: 16'h0103, r: 16'h3333});
    put(18'd3, 1'b1, 16'h3333, acc);
    e = q.pop_front();
    vectors++;
    if (acc !== 1'b1 || OUT_VALID !== 1'b1 || OUT_KEY !== e.k ||
        OUT_DATA_L !== e.l || OUT_DATA_R !== e.r ||
        OCCUPANCY !== 4'd7 || FULL !== 1'b0) begin
      miscompares++;
      $display("FAIL full_hit acc=%b ov=%b key=%h l=%h r=%h occ=%0d full=%b need 1/1/%h/%h/%h/7/0",
               acc, OUT_VALID, OUT_KEY, OUT_DATA_L, OUT_DATA_R, OCCUPANCY, FULL,
               e.k, e.l, e.r);
    end
    tick();
    do_reset();
  endtask

  task automatic test_back_to_back();
`ifndef MMCAM_DUP_DETECT_EN
    put(18'h2A, 1'b0, 16'h0001, acc);
    put(18'h2A, 1'b0, 16'h0002, acc);
    q.push_back('{k: 18'h2A, l: 16'h0001, r: 16'h0009});
    q.push_back('{k: 18'h2A, l: 16'h0002, r: 16'h0008});
    put(18'h2A, 1'b1, 16'h0009, acc);
    e = q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || OUT_DATA_L !== e.l || OUT_DATA_R !== e.r ||
        OCCUPANCY !== 4'd1) begin
      miscompares++;
      $display("FAIL lowest_first ov=%b l=%h r=%h occ=%0d need 1/%h/%h/1",
               OUT_VALID, OUT_DATA_L, OUT_DATA_R, OCCUPANCY, e.l, e.r);
    end
    put(18'h2A, 1'b1, 16'h0008, acc);
    e = q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || OUT_DATA_L !== e.l || OUT_DATA_R !== e.r ||
        OCCUPANCY !== 4'd0) begin
      miscompares++;
      $display("FAIL back_to_back ov=%b l=%h r=%h occ=%0d need 1/%h/%h/0",
               OUT_VALID, OUT_DATA_L, OUT_DATA_R, OCCUPANCY, e.l, e.r);
    end
    tick();
`endif
  endtask

  task automatic test_backpressure();
    put(18'h40, 1'b0, 16'h4040, acc);
    put(18'h41, 1'b0, 16'h4141, acc);
    OUT_READY = 1'b0;
    q.push_back('{k: 18'h40, l: 16'h4040, r: 16'h0404});
    put(18'h40, 1'b1, 16'h0404, acc);
    IN_VALID = 1'b1;
    IN_KEY   = 18'h41;
    IN_LR    = 1'b1;
    IN_DATA  = 16'h1414;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT_KEY !== q[0].k ||
          OUT_DATA_L !== q[0].l || OUT_DATA_R !== q[0].r) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d rdy=%b ov=%b key=%h l=%h r=%h need 0/1/%h/%h/%h",
                 c, IN_READY, OUT_VALID, OUT_KEY, OUT_DATA_L, OUT_DATA_R,
                 q[0].k, q[0].l, q[0].r);
      end
      tick();
    end
    OUT_READY = 1'b1;
    #1;
    vectors++;
    if (IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release rdy=%b need 1", IN_READY);
    end
    void'(q.pop_front());
    q.push_back('{k: 18'h41, l: 16'h4141, r: 16'h1414});
    tick();
    IN_VALID = 1'b0;
    e = q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || OUT_KEY !== e.k || OUT_DATA_L !== e.l ||
        OUT_DATA_R !== e.r || OCCUPANCY !== 4'd0) begin
      miscompares++;
      $display("FAIL bp_reload ov=%b key=%h l=%h r=%h occ=%0d need 1/%h/%h/%h/0",
               OUT_VALID, OUT_KEY, OUT_DATA_L, OUT_DATA_R, OCCUPANCY, e.k, e.l, e.r);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    put(18'h50, 1'b0, 16'h5050, acc);
    put(18'h51, 1'b0, 16'h5151, acc);
    put(18'h52, 1'b0, 16'h5252, acc);
    put(18'h53, 1'b0, 16'h5353, acc);
    OUT_READY = 1'b0;
    put(18'h53, 1'b1, 16'h3535, acc);
    MR = 1'b1;
    tick();
    MR = 1'b0;
    vectors++;
    if (OCCUPANCY !== 4'd0 || OUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset occ=%0d ov=%b need 0/0", OCCUPANCY, OUT_VALID);
    end
    OUT_READY = 1'b1;
    put(18'h50, 1'b1, 16'h0505, acc);
    vectors++;
    if (acc !== 1'b1 || OUT_VALID !== 1'b0 || OCCUPANCY !== 4'd1) begin
      miscompares++;
      $display("FAIL post_reset acc=%b ov=%b occ=%0d need 1/0/1", acc, OUT_VALID, OCCUPANCY);
    end
    do_reset();
  endtask

  task automatic test_duplicate();
    put(18'd7, 1'b0, 16'h0070, acc);
    put(18'd7, 1'b0, 16'h0071, acc);
`ifdef MMCAM_DUP_DETECT_EN
    vectors++;
    if (acc !== 1'b1 || OCCUPANCY !== 4'd1 || DUP_ERR !== 1'b1) begin
      miscompares++;
      $display("FAIL dup_drop acc=%b occ=%0d dup=%b need 1/1/1", acc, OCCUPANCY, DUP_ERR);
    end
`else
    vectors++;
    if (acc !== 1'b1 || OCCUPANCY !== 4'd2 || DUP_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL dup_store acc=%b occ=%0d dup=%b need 1/2/0", acc, OCCUPANCY, DUP_ERR);
    end
`endif
    tick();
    vectors++;
    if (DUP_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL dup_pulse dup=%b need 0", DUP_ERR);
    end
    do_reset();
  endtask

  initial begin
    @(negedge CP);
    test_reset();
    test_basic_pair();
    test_reverse();
    do_reset();
    test_partial_key();
    test_full();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_duplicate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmcam_match_store.md
Name: mmcam_match_store

Overview:
- Parametrised multi-entry matching memory for the data-driven pipeline; successor to the single-entry fire-detect cell.
- Holds up to DEPTH waiting operand tokens, keyed by color/generation/destination.
- An arriving token whose key equals a stored token's key with the opposite L/R side fires: the pair leaves as one packet through a registered valid/ready output, and the matched entry is freed.
- Sits between the token input queue and the instruction fetch stage.

Parameters:
- DEPTH, 8, number of waiting-token entries (2..64).
- KEY_W, 18, width of the color+gen+dest key (excludes the L/R bit).
- DATA_W, 16, operand payload width.

Ports:
- CP  in  1  clock; all state changes on the rising edge.
- MR  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  input token present.
- IN_READY  out  1  input token can be accepted this cycle.
- IN_KEY  in  KEY_W  token key.
- IN_LR  in  1  operand side: 0=L, 1=R.
- IN_DATA  in  DATA_W  operand value.
- OUT_VALID  out  1  fired packet present.
- OUT_READY  in  1  downstream accepts packet.
- OUT_KEY  out  KEY_W  key of the fired pair.
- OUT_DATA_L  out  DATA_W  L operand.
- OUT_DATA_R  out  DATA_W  R operand.
- OCCUPANCY  out  $clog2(DEPTH+1)  number of valid entries.
- FULL  out  1  OCCUPANCY == DEPTH.
- DUP_ERR  out  1  duplicate-token pulse (see Optional Feature).

Behaviour:
- Reset: MR sampled at the rising edge of CP; clock and reset exactly as already decided (one clock CP, synchronous active-high reset MR). MR has priority over all other activity. After MR:
  - all entries invalid; OCCUPANCY=0; FULL=0;
  - OUT_VALID=0; OUT_KEY/OUT_DATA_L/OUT_DATA_R=0; DUP_ERR=0.
  - Any packet pending at the output is discarded without handshake.
- Entry contents: valid bit, key, L/R bit, data.
- HIT (combinational): some valid entry has key == IN_KEY and LR != IN_LR. The matching entry is the lowest index among all such entries.
- Output slot is free when OUT_VALID=0 or OUT_READY=1.
- IN_READY = (output slot free) AND (HIT OR !FULL). IN_READY must not depend on IN_VALID.
- Accept = IN_VALID & IN_READY.
- On accept with HIT, at the next edge:
  - matching entry becomes invalid;
  - OUT_VALID=1, OUT_KEY=IN_KEY;
  - OUT_DATA_L = whichever of the stored/incoming operands has LR=0; OUT_DATA_R = the other;
  - OCCUPANCY decrements.
  - Latency: acceptance to OUT_VALID is exactly 1 cycle.
- On accept without HIT: token is written into the lowest-index invalid entry and OCCUPANCY increments. Output registers unchanged, except that OUT_VALID clears if OUT_READY=1.
- Output register:
  - Holds stable while OUT_VALID=1 and OUT_READY=0.
  - When OUT_READY=1 with no new fire, OUT_VALID clears at the next edge.
  - A new fire in the same cycle as a drain loads the new packet; back-to-back fires give 1 packet/cycle.
- Full and HIT: a token that matches is accepted even when FULL=1 (it frees an entry). A non-matching token is stalled (IN_READY=0).
- Multiple stored candidates (same key/opposite side): only the lowest index fires; the others remain.
- Same key, same side, no opposite entry present: stored as a new entry unless the Optional Feature is compiled in.
- Key compare covers all KEY_W bits; there is no partial match.

Optional Feature:
- Macro: MMCAM_DUP_DETECT_EN.
- Defined:
  - Define DUP = valid entry with key == IN_KEY and LR == IN_LR, and no HIT.
  - A DUP token does not need a free entry (IN_READY ignores FULL for it).
  - On acceptance it is dropped, with no write and no occupancy change.
  - DUP_ERR=1 for exactly one cycle after the accepting edge.
- Not defined: DUP_ERR tied to 0; duplicates are stored as ordinary entries.

Test Plan:
- Basic pair:
  - L token key=0x00123, data=0x1111; 2 cycles later R token key=0x00123, data=0x2222.
  - Required: OCCUPANCY 1→0; OUT_VALID=1 one cycle after the R accept; OUT_DATA_L=0x1111, OUT_DATA_R=0x2222.
- Reverse order:
  - R key=5, data=0xAAAA first, then L key=5, data=0xBBBB.
  - Required: OUT_DATA_L=0xBBBB, OUT_DATA_R=0xAAAA.
- Full:
  - Fill 8 L tokens, keys 0..7. Required: FULL=1.
  - R key=9 offered: IN_READY=0, no state change.
  - R key=3 offered: accepted; fires with entry 3; OCCUPANCY=7; FULL=0.
- Backpressure:
  - OUT_READY=0 with one packet held. Required: IN_READY=0; outputs stable for 5 cycles.
  - Then OUT_READY=1 while a new matching token is offered. Required: new packet loaded on the next edge with OUT_VALID staying 1.
- Reset mid-operation:
  - 3 stored entries plus a pending output; assert MR for 1 cycle.
  - Required: OCCUPANCY=0, OUT_VALID=0.
  - A following R key matching an earlier L does not fire; it is stored (OCCUPANCY=1).
- Duplicate (with MMCAM_DUP_DETECT_EN):
  - L key=7 twice.
  - Required: OCCUPANCY=1; DUP_ERR high one cycle.
  - Without the macro: OCCUPANCY=2; DUP_ERR=0.
